// File: rtl/mfp_sevenseg_scanner.sv
// Time-multiplexed 8-digit seven-segment scanner: snapshots the display
// register block once per frame and drives one anode per slot after a dead time.
module mfp_sevenseg_scanner #(
    parameter int SCAN_DIV    = 50000,
    parameter int DEAD_CYCLES = 64
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [7:0]  EN,
    input  logic [63:0] DIGITS,
    input  logic [7:0]  DP,
    output logic [7:0]  DISPENOUT,
    output logic [7:0]  DISPOUT,
    output logic        FRAME_TICK
);

    localparam int                CNT_W    = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]  DEAD_LIM = CNT_W'(DEAD_CYCLES);

    // Slot timing
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic             frame_start;
    logic             slot_last;

    // Frame snapshot of the register block
    logic [7:0]       snap_en_q;
    logic [63:0]      snap_digits_q;
    logic [7:0]       snap_dp_q;

    // Registered pins
    logic [7:0]       dispenout_q, dispenout_d;
    logic [7:0]       dispout_q, dispout_d;
    logic             frame_tick_q;

    logic [6:0]       glyph_seg [8];
    logic             dead_time;
    logic             digit_on;

    // Segment order within the 7-bit result is {g,f,e,d,c,b,a}, active-low.
    function automatic logic [6:0] glyph_decode(input logic [7:0] code);
        logic [6:0] seg;
        seg = 7'h7F;
        case (code)
            8'h00: seg = 7'h40;
            8'h01: seg = 7'h79;
            8'h02: seg = 7'h24;
            8'h03: seg = 7'h30;
            8'h04: seg = 7'h19;
            8'h05: seg = 7'h12;
            8'h06: seg = 7'h02;
            8'h07: seg = 7'h78;
            8'h08: seg = 7'h00;
            8'h09: seg = 7'h10;
            8'h0A: seg = 7'h08;
            8'h0B: seg = 7'h03;
            8'h0C: seg = 7'h46;
            8'h0D: seg = 7'h21;
            8'h0E: seg = 7'h06;
            8'h0F: seg = 7'h0E;
            8'h10: seg = 7'h7E;
            8'h11: seg = 7'h7D;
            8'h12: seg = 7'h7B;
            8'h13: seg = 7'h77;
            8'h14: seg = 7'h6F;
            8'h15: seg = 7'h5F;
            8'h16: seg = 7'h3F;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_glyph
            assign glyph_seg[gi] = glyph_decode(snap_digits_q[8*gi +: 8]);
        end
    endgenerate

    assign frame_start = (idx_q == 3'd0) && (cnt_q == '0);
    assign slot_last   = (cnt_q == CNT_LAST);
    assign dead_time   = (cnt_q < DEAD_LIM);
    assign digit_on    = ~snap_en_q[idx_q];

    always_comb begin
        cnt_d = slot_last ? '0 : cnt_q + 1'b1;
        idx_d = slot_last ? idx_q + 3'd1 : idx_q;
    end

    // Anode and segments computed from this cycle's state, landing one edge later.
    always_comb begin
        dispenout_d = 8'hFF;
        dispout_d   = 8'hFF;
        if (!dead_time && digit_on) begin
            dispenout_d = ~(8'd1 << idx_q);
            dispout_d   = {snap_dp_q[idx_q], glyph_seg[idx_q]};
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cnt_q         <= '0;
            idx_q         <= 3'd0;
            snap_en_q     <= 8'hFF;
            snap_digits_q <= '1;
            snap_dp_q     <= 8'hFF;
            dispenout_q   <= 8'hFF;
            dispout_q     <= 8'hFF;
            frame_tick_q  <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            dispenout_q  <= dispenout_d;
            dispout_q    <= dispout_d;
            frame_tick_q <= frame_start;
            // Slot (0,0) is always dead, so the stale snapshot is never shown.
            if (frame_start) begin
                snap_en_q     <= EN;
                snap_digits_q <= DIGITS;
                snap_dp_q     <= DP;
            end
        end
    end

    assign DISPENOUT  = dispenout_q;
    assign DISPOUT    = dispout_q;
    assign FRAME_TICK = frame_tick_q;

endmodule

// File: tb/tb_mfp_sevenseg_scanner.sv
// Scoreboard bench for the seven-segment scanner with SCAN_DIV=4, DEAD_CYCLES=1.
module tb_mfp_sevenseg_scanner;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic [7:0]  EN = 8'hFF;
    logic [63:0] DIGITS = '1;
    logic [7:0]  DP = 8'hFF;
    logic [7:0]  DISPENOUT;
    logic [7:0]  DISPOUT;
    logic        FRAME_TICK;

    mfp_sevenseg_scanner #(.SCAN_DIV(4), .DEAD_CYCLES(1)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .EN(EN), .DIGITS(DIGITS), .DP(DP),
        .DISPENOUT(DISPENOUT), .DISPOUT(DISPOUT), .FRAME_TICK(FRAME_TICK)
    );

    always #5 HCLK = ~HCLK;

    int edges = 0;
    always @(posedge HCLK) edges <= edges + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int         cyc;
        int         k;
        logic [7:0] an;
        logic [7:0] seg;
        logic       tick;
        string      name;
    } exp_t;

    exp_t sb_q[$];

    // Hand-computed per-digit segment byte and digit-enabled flag for the current frame
    logic [7:0] tab_seg [8];
    logic [7:0] tab_on;

    task automatic push_exp(input int cyc, input int k, input logic [7:0] an,
                            input logic [7:0] seg, input logic tick, input string name);
        exp_t e;
        e.cyc = cyc; e.k = k; e.an = an; e.seg = seg; e.tick = tick; e.name = name;
        sb_q.push_back(e);
    endtask

    // k = edge number after reset release; pins after edge k reflect cycle t=k-1.
    task automatic push_frame(input int base, input int k0, input int k1, input string name);
        for (int k = k0; k <= k1; k++) begin
            int t, cnt, idx;
            logic tick;
            t    = k - 1;
            cnt  = t % 4;
            idx  = (t / 4) % 8;
            tick = ((t % 32) == 0);
            if (cnt == 0 || !tab_on[idx])
                push_exp(base + k, k, 8'hFF, 8'hFF, tick, name);
            else
                push_exp(base + k, k, ~(8'd1 << idx), tab_seg[idx], tick, name);
        end
    endtask

    task automatic set_tab(input logic [7:0] on, input logic [7:0] s0, input logic [7:0] s1,
                           input logic [7:0] s2, input logic [7:0] s3, input logic [7:0] s4,
                           input logic [7:0] s5, input logic [7:0] s6, input logic [7:0] s7);
        tab_on = on;
        tab_seg[0] = s0; tab_seg[1] = s1; tab_seg[2] = s2; tab_seg[3] = s3;
        tab_seg[4] = s4; tab_seg[5] = s5; tab_seg[6] = s6; tab_seg[7] = s7;
    endtask

    task automatic start_test(input logic [7:0] en, input logic [63:0] digits,
                              input logic [7:0] dp, output int base);
        @(negedge HCLK);
        HRESETn = 1'b0;
        EN = en; DIGITS = digits; DP = dp;
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        base = edges;
    endtask

    task automatic drain(input string name);
        int w;
        w = 0;
        while (sb_q.size() > 0 && w < 1000) begin
            @(negedge HCLK);
            w++;
        end
        n_tests++;
        if (sb_q.size() > 0) begin
            n_fail++;
            $display("FAIL %s drain: %0d entries left, required 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    // Monitor: every cycle check the one-anode rule, then pop entries due this cycle.
    initial begin
        forever begin
            @(negedge HCLK);
            n_tests++;
            if ($countones(~DISPENOUT) > 1) begin
                n_fail++;
                $display("FAIL one_anode cyc=%0d: DISPENOUT=%h, required at most one low bit",
                         edges, DISPENOUT);
            end
            while (sb_q.size() > 0 && sb_q[0].cyc <= edges) begin
                exp_t e;
                e = sb_q.pop_front();
                n_tests++;
                if (e.cyc < edges) begin
                    n_fail++;
                    $display("FAIL %s k=%0d: missed at cyc %0d, required at cyc %0d",
                             e.name, e.k, edges, e.cyc);
                end else if (DISPENOUT !== e.an || DISPOUT !== e.seg || FRAME_TICK !== e.tick) begin
                    n_fail++;
                    $display("FAIL %s k=%0d: got an=%h seg=%h tick=%b, required an=%h seg=%h tick=%b",
                             e.name, e.k, DISPENOUT, DISPOUT, FRAME_TICK, e.an, e.seg, e.tick);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int base;

        // Reset state
        @(negedge HCLK);
        push_exp(edges + 1, 0, 8'hFF, 8'hFF, 1'b0, "reset_state");
        push_exp(edges + 2, 0, 8'hFF, 8'hFF, 1'b0, "reset_state");
        drain("reset_state");

        // Single digit 0 showing '8' with dp off, two full frames
        set_tab(8'h01, 8'h80, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        start_test(8'hFE, 64'hFFFF_FFFF_FFFF_FF08, 8'hFF, base);
        push_frame(base, 1, 66, "digit0_only");
        drain("digit0_only");

        // All digits 0..7, dp on digit 2
        set_tab(8'hFF, 8'hC0, 8'hF9, 8'h24, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8);
        start_test(8'h00, 64'h0706_0504_0302_0100, 8'hFB, base);
        push_frame(base, 1, 34, "all_digits");
        drain("all_digits");

        // Mid-frame input change must wait for the next snapshot
        set_tab(8'h21, 8'hF9, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h92, 8'hFF, 8'hFF);
        start_test(8'hDE, 64'hFFFF_05FF_FFFF_FF01, 8'hFF, base);
        push_frame(base, 1, 32, "no_tearing_f1");
        set_tab(8'h21, 8'h88, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h88, 8'hFF, 8'hFF);
        push_frame(base, 33, 58, "no_tearing_f2");
        while (edges < base + 14) @(negedge HCLK);
        DIGITS = 64'hFFFF_0AFF_FFFF_FF0A;
        drain("no_tearing");

        // Single-segment and blank codes, dp lit everywhere
        set_tab(8'h3F, 8'h7E, 8'h3F, 8'h7F, 8'h7F, 8'h0E, 8'h7D, 8'hFF, 8'hFF);
        start_test(8'hC0, 64'hFFFF_110F_FF17_1610, 8'h00, base);
        push_frame(base, 1, 25, "special_codes");
        drain("special_codes");

        // Asynchronous reset in the middle of digit 5's slot
        set_tab(8'hFF, 8'hC0, 8'hF9, 8'h24, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8);
        start_test(8'h00, 64'h0706_0504_0302_0100, 8'hFB, base);
        push_frame(base, 1, 21, "pre_reset");
        do begin
            @(posedge HCLK);
            #2;
        end while (edges < base + 22);
        HRESETn = 1'b0;
        for (int k = 22; k <= 24; k++)
            push_exp(base + k, k, 8'hFF, 8'hFF, 1'b0, "mid_slot_reset");
        repeat (3) @(negedge HCLK);
        DP = 8'hFF;
        HRESETn = 1'b1;
        base = edges;
        set_tab(8'hFF, 8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8);
        push_frame(base, 1, 14, "restart");
        drain("restart");

        repeat (2) @(negedge HCLK);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mfp_sevenseg_scanner.md
MFP_SEVENSEG_SCANNER -- requirements
Module: mfp_sevenseg_scanner

Interface
REQ-001 SHALL provide parameter SCAN_DIV, default 50000, meaning HCLK cycles per digit slot; legal range 2..65535.
REQ-002 SHALL provide parameter DEAD_CYCLES, default 64, meaning blanked cycles at the start of each slot; legal range 1..SCAN_DIV-1.
REQ-003 SHALL have HCLK  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have HRESETn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have EN  input  8  per-digit enable from the display register block, active-low (bit i = digit i).
REQ-006 SHALL have DIGITS  input  64  glyph codes, digit i code = DIGITS[8i+7:8i].
REQ-007 SHALL have DP  input  8  per-digit decimal point, active-low.
REQ-008 SHALL have DISPENOUT  output  8  digit anode drives, active-low, registered.
REQ-009 SHALL have DISPOUT  output  8  segments {dp,g,f,e,d,c,b,a}, active-low, registered.
REQ-010 SHALL have FRAME_TICK  output  1  one-cycle pulse when a new input snapshot is loaded.

Function
REQ-011 SHALL hold slot counter cnt (0..SCAN_DIV-1) and digit index idx (0..7); cnt increments every cycle; at SCAN_DIV-1 cnt wraps to 0 and idx increments, 7 wrapping to 0.
REQ-012 SHALL load snapshot registers from EN, DIGITS, DP at the clock edge ending any cycle with idx=0 and cnt=0; inputs are ignored at all other times (no tearing mid-frame).
REQ-013 SHALL assert FRAME_TICK for exactly the one cycle following each snapshot load.
REQ-014 SHALL register pins: value after edge n+1 = function of (idx, cnt, snapshot) during cycle n; one-cycle latency.
REQ-015 SHALL drive DISPENOUT=8'hFF and DISPOUT=8'hFF when cnt < DEAD_CYCLES (dead-time).
REQ-016 SHALL otherwise drive DISPENOUT with only bit idx low if snapshot EN[idx]=0, else 8'hFF; DISPOUT=8'hFF whenever the selected digit is disabled.
REQ-017 SHALL decode code 0x00-0x0F to hex glyphs, DISPOUT[6:0] = 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex, 0..F).
REQ-018 SHALL decode code 0x10+k (k=0..6) to only segment k lit (a=0..g=6), i.e. DISPOUT[k]=0, others 1.
REQ-019 SHALL decode codes 0x17-0xFF to blank, DISPOUT[6:0]=7'h7F.
REQ-020 SHALL set DISPOUT[7] = snapshot DP[idx] for an enabled digit, independent of glyph code (blank code with DP=0 lights dp only).
REQ-021 SHALL never drive more than one DISPENOUT bit low in any cycle.
REQ-022 SHALL produce a full frame every 8*SCAN_DIV cycles, FRAME_TICK period exactly 8*SCAN_DIV.

Reset
REQ-023 SHALL on HRESETn low, asynchronously: cnt=0, idx=0, snapshot EN=8'hFF, DIGITS=all 1s, DP=8'hFF, DISPENOUT=8'hFF, DISPOUT=8'hFF, FRAME_TICK=0.
REQ-024 SHALL on reset assertion mid-slot blank all outputs immediately (no partial slot completion).
REQ-025 SHALL take the first snapshot at the first rising edge after HRESETn release (state idx=0,cnt=0), with FRAME_TICK high for the following cycle.

Verification (SCAN_DIV=4, DEAD_CYCLES=1)
REQ-026 SHALL cover: EN=8'hFE, DIGITS[7:0]=8'h08, DP=8'hFF, release reset -> FRAME_TICK after edge 1; DISPENOUT=FE, DISPOUT=80 for 3 cycles of each 4-cycle digit-0 slot, all FF elsewhere; period 32.
REQ-027 SHALL cover: EN=00, DIGITS=64'h0706050403020100, DP=8'hFB -> slot i shows glyph i; digit 2 DISPOUT=24 (dp lit), digit 0 DISPOUT=C0; exactly one anode low.
REQ-028 SHALL cover: change DIGITS[7:0] 0x01->0x0A during digit 3 slot -> digit 0 keeps F9 this frame, shows 88 only after next FRAME_TICK.
REQ-029 SHALL cover: codes 0x10, 0x16, 0x17, 0xFF with DP=0 -> DISPOUT 7E, 3F, 7F, 7F respectively (bit7=0).
REQ-030 SHALL cover: HRESETn pulsed low mid-slot of digit 5 -> DISPENOUT=FF, DISPOUT=FF during reset; scan restarts at digit 0 with new snapshot.
